// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch front-panel controller.
package stopwatch_ctrl_pkg;

    // State encoding also drives the status LEDs directly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_t;

    // Datapath controls for a given state, packed as {sw_en, pause}.
    function automatic logic [1:0] drive_for(input state_t st);
        logic [1:0] drv;
        case (st)
            ST_RUN:  drv = 2'b10;
            ST_LAP:  drv = 2'b11;
            default: drv = 2'b00;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debounce counter and
// a one-cycle press pulse on each accepted 0->1 change of the stable level.
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned         DEB_W      = 20,
    parameter logic [DEB_W-1:0]    DEB_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [DEB_W-1:0] CNT_MAX = DEB_CYCLES - 1'b1;

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [DEB_W-1:0] cnt;

    // Synchronise the raw button, then accept a new level only after it has
    // differed from the stable level for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= sync2;
                    cnt    <= '0;
                    press  <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: debounces the two buttons, runs the
// IDLE/RUN/STOP/LAP state machine and drives the datapath controls.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned      DEB_W      = 20,
    parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd500000,
    parameter bit               AUTO_STOP  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic       time_out,
    output logic       sw_en,
    output logic       pause,
    output logic       clear,
    output logic [1:0] state
);

    logic   press_ss;
    logic   press_lr;
    logic   ss_level;
    logic   lr_level;
    logic   unused_levels;
    logic   time_out_q;
    logic   to_rise;
    state_t state_q;
    state_t next_state;
    logic   do_clear;

    btn_debounce #(
        .DEB_W      (DEB_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_ss (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_ss),
        .level   (ss_level),
        .press   (press_ss)
    );

    btn_debounce #(
        .DEB_W      (DEB_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_lr (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_lr),
        .level   (lr_level),
        .press   (press_lr)
    );

    // Stable levels are not needed here; only the press pulses matter.
    assign unused_levels = ss_level ^ lr_level;

    assign to_rise = time_out & ~time_out_q;

    // Next-state decode: start/stop wins over lap/reset, a losing lr press is dropped.
    always_comb begin
        next_state = state_q;
        do_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_ss) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (press_ss)                    next_state = ST_STOP;
                else if (press_lr)               next_state = ST_LAP;
                else if (AUTO_STOP && to_rise)   next_state = ST_STOP;
            end
            ST_LAP: begin
                if (press_ss)                    next_state = ST_STOP;
                else if (press_lr)               next_state = ST_RUN;
                else if (AUTO_STOP && to_rise)   next_state = ST_STOP;
            end
            ST_STOP: begin
                if (press_ss) begin
                    next_state = ST_RUN;
                end else if (press_lr) begin
                    next_state = ST_IDLE;
                    do_clear   = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State and registered outputs update together from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sw_en      <= 1'b0;
            pause      <= 1'b0;
            clear      <= 1'b0;
            time_out_q <= 1'b0;
        end else begin
            state_q        <= next_state;
            {sw_en, pause} <= drive_for(next_state);
            clear          <= do_clear;
            time_out_q     <= time_out;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues the expected
// {state, sw_en, pause, clear} after each action, a monitor pops one entry
// whenever the observed outputs change.
module tb_stopwatch_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       pa;
        logic       cl;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       time_out = 1'b0;
    logic       sw_en;
    logic       pause;
    logic       clear;
    logic [1:0] state;

    obs_t exp_q[$];
    obs_t prev;
    bit   mon_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .DEB_W      (3),
        .DEB_CYCLES (3'd4),
        .AUTO_STOP  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_ss   (btn_ss),
        .btn_lr   (btn_lr),
        .time_out (time_out),
        .sw_en    (sw_en),
        .pause    (pause),
        .clear    (clear),
        .state    (state)
    );

    function automatic obs_t mk(input logic [1:0] st, input logic en,
                                input logic pa, input logic cl);
        obs_t o;
        o.st = st;
        o.en = en;
        o.pa = pa;
        o.cl = cl;
        return o;
    endfunction

    task automatic check(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Monitor: every change of the observed outputs consumes one expected entry.
    always @(negedge clk) begin
        obs_t cur;
        obs_t e;
        cur = mk(state, sw_en, pause, clear);
        if (mon_en) begin
            if (prev.cl)
                check("clear_one_cycle", int'(cur.cl), 0);
            if (cur != prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_change actual=%0h required=none at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("transition", int'(cur), int'(e));
                end
            end
            prev = cur;
        end
    end

    task automatic press(input bit ss, input bit lr);
        @(posedge clk); #1;
        btn_ss = ss;
        btn_lr = lr;
        repeat (8) @(posedge clk);
        #1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", int'(state), 0);
        check("reset_sw_en", int'(sw_en), 0);
        check("reset_pause", int'(pause), 0);
        check("reset_clear", int'(clear), 0);
        prev   = mk(state, sw_en, pause, clear);
        mon_en = 1'b1;
        rst    = 1'b1;

        // 1: held start/stop press -> RUN
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0));
        press(1'b1, 1'b0);

        // 2: two-cycle glitch is filtered out
        @(posedge clk); #1;
        btn_ss = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btn_ss = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("glitch_cnt", int'(dut.u_deb_ss.cnt), 0);
        check("glitch_state", int'(state), 1);

        // Return to IDLE through reset
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 3: ss, lr, lr, ss
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0));
        press(1'b1, 1'b0);
        exp_q.push_back(mk(2'd3, 1'b1, 1'b1, 1'b0));
        press(1'b0, 1'b1);
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0));
        press(1'b0, 1'b1);
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b0);

        // 4: lr in STOP -> IDLE with a single clear pulse
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0));
        press(1'b0, 1'b1);

        // 5: time_out rising edge in RUN auto-stops; held level does not
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0));
        press(1'b1, 1'b0);
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        time_out = 1'b1;
        repeat (5) @(posedge clk);
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0));
        press(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        time_out = 1'b0;
        repeat (3) @(posedge clk);

        // 6: simultaneous presses in RUN -> STOP only
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b1);
        repeat (5) @(posedge clk);

        // Reset in the middle of LAP
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0));
        press(1'b1, 1'b0);
        exp_q.push_back(mk(2'd3, 1'b1, 1'b1, 1'b0));
        press(1'b0, 1'b1);
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midlap_rst_state", int'(state), 0);
        check("midlap_rst_sw_en", int'(sw_en), 0);
        check("midlap_rst_pause", int'(pause), 0);
        check("midlap_rst_clear", int'(clear), 0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst_clear", int'(clear), 0);

        // Every queued expectation must have been observed
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
